pipe_issue_sched: RTL and testbench

- Issue scheduler in front of the 4-stage register-bank ALU pipeline.
- Arbitrates two instruction requesters round-robin and registers the winning instruction onto the pipeline issue bus.
- Holds any instruction whose source registers are still in flight. The pipeline has no forwarding, so this is a scoreboard stall.
- Supports a drain handshake so software can quiesce the pipeline before reading the register bank or memory.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_scoreboard.sv | 62 ++++++
 rtl/pipe_issue_sched.sv | 142 ++++++++++++++
 tb/tb_pipe_issue_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the ALU pipeline issue scheduler.
// Holds the instruction layout, the scheduler FSM states and the pipeline
// latency / function-code limits used by the scheduler and its scoreboard.
package pipe_pkg;

  localparam int PIPE_LAT = 3;   // cycles from issue until rd is written
  localparam int NREG_W   = 4;   // register-index width (16 registers)
  localparam int FUNC_W   = 4;   // function-code width
  localparam int ADDR_W   = 8;   // memory-address width
  localparam int MAX_FUNC = 11;  // highest legal function code

  localparam int INSTR_W  = NREG_W * 3 + FUNC_W + ADDR_W;

  // Field order matches the requester bus packing {rs1, rs2, rd, func, addr}.
  typedef struct packed {
    logic [NREG_W-1:0] rs1;
    logic [NREG_W-1:0] rs2;
    logic [NREG_W-1:0] rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } sched_state_e;

  // Codes above MAX_FUNC still issue; the pipeline writes Z for them.
  function automatic logic func_illegal(input logic [FUNC_W-1:0] f);
    return f > FUNC_W'(MAX_FUNC);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker: a DEPTH-slot shift register of {v, rd}.
// Ports: clk1/rst, push + push_rd (issue this cycle), rs1/rs2 of both
// requesters; outputs blocked[1:0] (RAW hazard per requester) and empty.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT,
  parameter int RW    = NREG_W
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          push,
  input  logic [RW-1:0] push_rd,
  input  logic [RW-1:0] rs1_0,
  input  logic [RW-1:0] rs2_0,
  input  logic [RW-1:0] rs1_1,
  input  logic [RW-1:0] rs2_1,
  output logic [1:0]    blocked,
  output logic          empty
);

  logic [DEPTH-1:0] slot_v;
  logic [RW-1:0]    slot_rd [DEPTH];

  // Slot k holds an instruction issued k+1 edges ago; the last slot falls
  // off exactly when its result lands in the register bank.
  always_ff @(posedge clk1) begin
    if (rst) begin
      slot_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd[k] <= '0;
      end
    end else begin
      slot_v[0]  <= push;
      slot_rd[0] <= push_rd;
      for (int k = 1; k < DEPTH; k++) begin
        slot_v[k]  <= slot_v[k-1];
        slot_rd[k] <= slot_rd[k-1];
      end
    end
  end

  // Only source operands are compared: writeback is in order, so a
  // pending write to the same rd is harmless, and an instruction's own rd
  // never enters this compare before it issues.
  always_comb begin
    blocked = 2'b00;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_v[k]) begin
        if ((rs1_0 == slot_rd[k]) || (rs2_0 == slot_rd[k])) begin
          blocked[0] = 1'b1;
        end
        if ((rs1_1 == slot_rd[k]) || (rs2_1 == slot_rd[k])) begin
          blocked[1] = 1'b1;
        end
      end
    end
  end

  assign empty = ~|slot_v;

endmodule

// File: rtl/pipe_issue_sched.sv
// Issue scheduler: round-robin arbiter over two requesters with a RAW
// scoreboard stall and a drain/quiesce handshake, registered issue bus.
// Ports: req_valid/req_ready + req0/req1_instr in; iss_* (valid one cycle
// after the handshake), illegal, drain_req/drained, issue_cnt out.
module pipe_issue_sched
  import pipe_pkg::*;
(
  input  logic               clk1,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic               iss_valid,
  output logic [NREG_W-1:0]  iss_rs1,
  output logic [NREG_W-1:0]  iss_rs2,
  output logic [NREG_W-1:0]  iss_rd,
  output logic [FUNC_W-1:0]  iss_func,
  output logic [ADDR_W-1:0]  iss_addr,
  output logic               iss_src,
  output logic               illegal,
  input  logic               drain_req,
  output logic               drained,
  output logic [15:0]        issue_cnt
);

  instr_t       in0;
  instr_t       in1;
  instr_t       sel;
  sched_state_e state;
  sched_state_e state_nxt;
  logic         ptr;
  logic [1:0]   blocked;
  logic         sb_empty;
  logic         grant_open;
  logic [1:0]   eligible;
  logic [1:0]   grant;
  logic         issue;
  logic         win;

  assign in0 = instr_t'(req0_instr);
  assign in1 = instr_t'(req1_instr);

  pipe_scoreboard #(
    .DEPTH (PIPE_LAT),
    .RW    (NREG_W)
  ) u_sb (
    .clk1    (clk1),
    .rst     (rst),
    .push    (issue),
    .push_rd (sel.rd),
    .rs1_0   (in0.rs1),
    .rs2_0   (in0.rs2),
    .rs1_1   (in1.rs1),
    .rs2_1   (in1.rs2),
    .blocked (blocked),
    .empty   (sb_empty)
  );

  // Grants are allowed in RUN without a drain request, and also in DRAINED
  // in the very cycle drain_req drops, so a waiting requester goes out with
  // no dead cycle after the quiesce is released.
  assign grant_open = ~drain_req && ((state == RUN) || (state == DRAINED));
  assign eligible   = req_valid & ~blocked & {2{grant_open}};

  // When only one side is eligible it wins regardless of the pointer, so a
  // stalled pointer side never idles the pipeline.
  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = eligible;
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign win       = grant[1];
  assign sel       = win ? in1 : in0;

  // Next-state and drained output.
  always_comb begin
    state_nxt = state;
    drained   = 1'b0;
    case (state)
      RUN: begin
        if (drain_req) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (sb_empty) begin
          state_nxt = DRAINED;
        end
      end
      DRAINED: begin
        // drained follows drain_req combinationally so it falls in the
        // same cycle software releases the request.
        drained = drain_req;
        if (!drain_req) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= RUN;
      ptr       <= 1'b0;
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      iss_src   <= 1'b0;
      illegal   <= 1'b0;
      issue_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      iss_valid <= issue;
      illegal   <= issue && func_illegal(sel.func);
      // Issue fields hold their last value between strobes.
      if (issue) begin
        iss_rs1   <= sel.rs1;
        iss_rs2   <= sel.rs2;
        iss_rd    <= sel.rd;
        iss_func  <= sel.func;
        iss_addr  <= sel.addr;
        iss_src   <= win;
        ptr       <= ~win;
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_sched.sv
module tb_pipe_issue_sched;

  localparam int PL   = 3;
  localparam int MAXF = 11;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [23:0] req0_instr;
  logic [23:0] req1_instr;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic        iss_src;
  logic        illegal;
  logic        drain_req;
  logic        drained;
  logic [15:0] issue_cnt;
  logic [23:0] iss_cat;

  assign iss_cat = {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};

  pipe_issue_sched dut (
    .clk1       (clk1),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_instr (req0_instr),
    .req1_instr (req1_instr),
    .iss_valid  (iss_valid),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rd     (iss_rd),
    .iss_func   (iss_func),
    .iss_addr   (iss_addr),
    .iss_src    (iss_src),
    .illegal    (illegal),
    .drain_req  (drain_req),
    .drained    (drained),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk1 = ~clk1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a register is busy through the last cycle before its
  // result is written, i.e. for PL cycles after the issuing edge.
  int          cyc;
  int          busy_until [16];
  int          mode;          // 0 run, 1 drain, 2 drained
  bit          ptr;
  logic [15:0] m_cnt;
  bit          e_iv, e_src, e_ill, e_drained;
  logic [23:0] e_instr;
  bit   [1:0]  e_ready;

  function automatic logic [23:0] mk(input int rs1, input int rs2, input int rd,
                                     input int fn, input int ad);
    return {4'(rs1), 4'(rs2), 4'(rd), 4'(fn), 8'(ad)};
  endfunction

  function automatic bit m_blocked(input logic [23:0] ins);
    return (busy_until[ins[23:20]] >= cyc) || (busy_until[ins[19:16]] >= cyc);
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int r = 0; r < 16; r++) busy_until[r] = -1;
    mode = 0; ptr = 0; m_cnt = 16'd0;
    e_iv = 0; e_src = 0; e_ill = 0; e_instr = 24'd0;
  endtask

  task automatic model_comb();
    bit open, el0, el1;
    open = !drain_req && (mode != 1);
    el0  = req_valid[0] && !m_blocked(req0_instr) && open;
    el1  = req_valid[1] && !m_blocked(req1_instr) && open;
    if (el0 && el1) e_ready = ptr ? 2'b10 : 2'b01;
    else            e_ready = {el1, el0};
    e_drained = (mode == 2) && drain_req;
  endtask

  task automatic model_edge();
    bit empty;
    logic [23:0] ins;
    empty = 1;
    for (int r = 0; r < 16; r++) if (busy_until[r] >= cyc) empty = 0;
    if (e_ready != 2'b00) begin
      ins = e_ready[1] ? req1_instr : req0_instr;
      busy_until[ins[15:12]] = cyc + PL;
      e_iv = 1; e_instr = ins; e_src = e_ready[1];
      e_ill = (ins[11:8] > MAXF);
      m_cnt = m_cnt + 16'd1;
      ptr = !e_ready[1];
    end else begin
      e_iv = 0; e_ill = 0;
    end
    case (mode)
      0: if (drain_req) mode = 1;
      1: if (empty) mode = 2;
      default: if (!drain_req) mode = 0;
    endcase
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic apply(input bit [1:0] v, input logic [23:0] i0,
                       input logic [23:0] i1, input bit dr);
    @(negedge clk1);
    req_valid = v; req0_instr = i0; req1_instr = i1; drain_req = dr;
    #1;
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk1);
    model_edge();
  endtask

  task automatic test_reset();
    req_valid = 0; drain_req = 0; req0_instr = 0; req1_instr = 0;
    do_reset();
    apply(2'b00, 24'd0, 24'd0, 0);
    n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    n_tests++; if (iss_cat !== 24'd0) begin n_fail++; $display("FAIL reset_iss_fields got %h want 0", iss_cat); end
    n_tests++; if (iss_src !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_src_illegal got %b%b want 00", iss_src, illegal); end
    n_tests++; if (issue_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", issue_cnt); end
    n_tests++; if (drained !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_drained_ready got %b %b want 0 00", drained, req_ready); end
    advance();
  endtask

  task automatic test_independent();
    logic [23:0] add_i, sub_i;
    add_i = mk(2, 3, 1, 0, 8'h10);
    sub_i = mk(5, 6, 4, 1, 8'h20);
    do_reset();
    apply(2'b11, add_i, sub_i, 0);
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL indep_first_grant got %b want 01", req_ready); end
    advance();
    apply(2'b10, add_i, sub_i, 0);
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL indep_second_grant got %b want 10", req_ready); end
    n_tests++; if (iss_valid !== 1'b1 || iss_src !== 1'b0 || iss_cat !== add_i) begin n_fail++; $display("FAIL indep_iss0 got v%b s%b %h want v1 s0 %h", iss_valid, iss_src, iss_cat, add_i); end
    advance();
    apply(2'b00, add_i, sub_i, 0);
    n_tests++; if (iss_valid !== 1'b1 || iss_src !== 1'b1 || iss_cat !== sub_i) begin n_fail++; $display("FAIL indep_iss1 got v%b s%b %h want v1 s1 %h", iss_valid, iss_src, iss_cat, sub_i); end
    n_tests++; if (issue_cnt !== 16'd2) begin n_fail++; $display("FAIL indep_cnt got %0d want 2", issue_cnt); end
    advance();
  endtask

  task automatic test_raw_stall();
    int gcyc;
    bit got;
    do_reset();
    apply(2'b01, mk(1, 2, 5, 0, 0), 24'd0, 0);
    advance();
    gcyc = -1;
    for (int k = 1; k <= 8; k++) begin
      apply(2'b01, mk(5, 0, 6, 2, 1), 24'd0, 0);
      got = req_ready[0];
      if (got) gcyc = k;
      advance();
      if (got) break;
    end
    n_tests++; if (gcyc != PL + 1) begin n_fail++; $display("FAIL raw_stall_issue_cycle got %0d want %0d", gcyc, PL + 1); end
    apply(2'b00, 24'd0, 24'd0, 0);
    n_tests++; if (iss_valid !== 1'b1 || iss_rs1 !== 4'd5) begin n_fail++; $display("FAIL raw_stall_iss got v%b rs1 %0d want v1 rs1 5", iss_valid, iss_rs1); end
    advance();
  endtask

  task automatic test_bypass();
    bit [1:0] want [4];
    bit [1:0] vin;
    want = '{2'b10, 2'b00, 2'b00, 2'b01};
    do_reset();
    apply(2'b01, mk(1, 2, 5, 0, 0), 24'd0, 0);
    advance();
    for (int k = 0; k < 4; k++) begin
      vin = (k == 0) ? 2'b11 : 2'b01;
      apply(vin, mk(5, 1, 9, 3, 2), mk(7, 8, 10, 4, 3), 0);
      n_tests++; if (req_ready !== want[k]) begin n_fail++; $display("FAIL bypass_grant_c%0d got %b want %b", k + 1, req_ready, want[k]); end
      if (k == 1) begin
        n_tests++; if (iss_valid !== 1'b1 || iss_src !== 1'b1 || iss_rd !== 4'd10) begin n_fail++; $display("FAIL bypass_iss_req1 got v%b s%b rd%0d want v1 s1 rd10", iss_valid, iss_src, iss_rd); end
      end
      advance();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    apply(2'b01, mk(1, 2, 3, 12, 8'h55), 24'd0, 0);
    advance();
    apply(2'b01, mk(1, 2, 3, 11, 8'h56), 24'd0, 0);
    n_tests++; if (illegal !== 1'b1 || iss_valid !== 1'b1 || iss_func !== 4'd12) begin n_fail++; $display("FAIL illegal_pulse got ill%b v%b f%0d want 1 1 12", illegal, iss_valid, iss_func); end
    n_tests++; if (issue_cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_cnt got %0d want 1", issue_cnt); end
    advance();
    apply(2'b00, 24'd0, 24'd0, 0);
    n_tests++; if (illegal !== 1'b0 || iss_func !== 4'd11) begin n_fail++; $display("FAIL illegal_max_func got ill%b f%0d want 0 11", illegal, iss_func); end
    advance();
    apply(2'b00, 24'd0, 24'd0, 0);
    n_tests++; if (iss_valid !== 1'b0 || illegal !== 1'b0 || iss_addr !== 8'h56) begin n_fail++; $display("FAIL illegal_hold got v%b ill%b a%h want 0 0 56", iss_valid, illegal, iss_addr); end
    advance();
  endtask

  task automatic test_drain();
    int  edges;
    bit  seen, gbad;
    logic [23:0] pend;
    pend = mk(8, 9, 10, 1, 7);
    do_reset();
    apply(2'b01, mk(1, 2, 3, 0, 0), 24'd0, 0);
    advance();
    edges = -1; gbad = 0;
    for (int k = 0; k <= 8; k++) begin
      apply(2'b01, pend, 24'd0, 1);
      if (req_ready !== 2'b00) gbad = 1;
      seen = drained;
      if (seen) edges = k;
      advance();
      if (seen) break;
    end
    n_tests++; if (gbad) begin n_fail++; $display("FAIL drain_no_grant got grant want none"); end
    n_tests++; if (edges != PL + 1) begin n_fail++; $display("FAIL drain_latency got %0d want %0d", edges, PL + 1); end
    apply(2'b01, pend, 24'd0, 0);
    n_tests++; if (drained !== 1'b0 || req_ready !== 2'b01) begin n_fail++; $display("FAIL drain_release got d%b r%b want 0 01", drained, req_ready); end
    advance();
    apply(2'b00, pend, 24'd0, 0);
    n_tests++; if (iss_valid !== 1'b1 || iss_cat !== pend) begin n_fail++; $display("FAIL drain_release_iss got v%b %h want v1 %h", iss_valid, iss_cat, pend); end
    advance();
  endtask

  task automatic test_drain_empty();
    int edges;
    bit seen;
    do_reset();
    edges = -1;
    for (int k = 0; k <= 6; k++) begin
      apply(2'b00, 24'd0, 24'd0, 1);
      seen = drained;
      if (seen) edges = k;
      advance();
      if (seen) break;
    end
    n_tests++; if (edges != 2) begin n_fail++; $display("FAIL drain_empty_latency got %0d want 2", edges); end
  endtask

  task automatic test_wrap();
    logic [23:0] a, b;
    int guard;
    a = mk(1, 2, 3, 0, 1);
    b = mk(4, 5, 6, 1, 2);
    do_reset();
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      apply(2'b11, a, b, 0);
      advance();
      guard++;
    end
    apply(2'b01, a, b, 0);
    n_tests++; if (issue_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", issue_cnt); end
    advance();
    apply(2'b00, a, b, 0);
    n_tests++; if (issue_cnt !== 16'h0000 || iss_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got %h v%b want 0000 v1", issue_cnt, iss_valid); end
    advance();
  endtask

  task automatic test_reset_mid_drain();
    logic [23:0] haz;
    haz = mk(5, 0, 7, 2, 9);
    do_reset();
    apply(2'b01, mk(1, 2, 5, 0, 0), 24'd0, 0);
    advance();
    apply(2'b01, haz, 24'd0, 1);
    advance();
    apply(2'b01, haz, 24'd0, 1);
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL middrain_blocked got %b want 00", req_ready); end
    advance();
    drain_req = 0;
    do_reset();
    apply(2'b01, haz, 24'd0, 0);
    n_tests++; if (req_ready !== 2'b01 || drained !== 1'b0) begin n_fail++; $display("FAIL middrain_after_reset got r%b d%b want 01 0", req_ready, drained); end
    advance();
    apply(2'b00, haz, 24'd0, 0);
    n_tests++; if (iss_valid !== 1'b1 || iss_cat !== haz) begin n_fail++; $display("FAIL middrain_iss got v%b %h want v1 %h", iss_valid, iss_cat, haz); end
    advance();
  endtask

  task automatic test_random();
    bit          p0, p1, dr;
    logic [23:0] i0, i1;
    bit   [1:0]  g;
    do_reset();
    p0 = 0; p1 = 0; dr = 0; i0 = 0; i1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1;
        i0 = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255));
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1;
        i1 = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255));
      end
      if ($urandom_range(0, 29) == 0) dr = !dr;
      apply({p1, p0}, i0, i1, dr);
      n_tests++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rand_ready c%0d got %b want %b", n, req_ready, e_ready); end
      n_tests++; if (drained !== e_drained) begin n_fail++; $display("FAIL rand_drained c%0d got %b want %b", n, drained, e_drained); end
      n_tests++; if (iss_valid !== e_iv || illegal !== e_ill) begin n_fail++; $display("FAIL rand_strobe c%0d got v%b i%b want v%b i%b", n, iss_valid, illegal, e_iv, e_ill); end
      n_tests++; if (iss_cat !== e_instr || iss_src !== e_src || issue_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_bus c%0d got %h s%b n%0d want %h s%b n%0d", n, iss_cat, iss_src, issue_cnt, e_instr, e_src, m_cnt); end
      g = e_ready;
      advance();
      if (g[0]) p0 = 0;
      if (g[1]) p1 = 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_independent();
    test_raw_stall();
    test_bypass();
    test_illegal();
    test_drain();
    test_drain_empty();
    test_reset_mid_drain();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
